// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues ROM reads with a
// bounded ack wait, and hands each fetched word to the control unit.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              en_pc_pulse,
  input  logic [1:0]        pc_ctrl,
  input  logic [ADDR_W-1:0] offset_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ins,
  output logic              en_in,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    WAIT_PC
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_JMP  = 2'b10,
    PC_REL  = 2'b11
  } pc_sel_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] pc_next;

  assign rom_addr = pc;

  // Relative branches add the offset modulo 2^ADDR_W, which is the same as a
  // signed add of a two's-complement offset.
  always_comb begin
    pc_next = pc;
    case (pc_sel_t'(pc_ctrl))
      PC_HOLD: pc_next = pc;
      PC_INC:  pc_next = pc + ADDR_W'(1);
      PC_JMP:  pc_next = offset_addr;
      PC_REL:  pc_next = pc + offset_addr;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      ins      <= '0;
      en_in    <= 1'b0;
      rom_req  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          en_in <= 1'b0;
          if (en) begin
            state    <= FETCH;
            rom_req  <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
          end
        end

        // An ack in the last allowed cycle wins over the timeout.
        FETCH: begin
          if (rom_ack) begin
            ins     <= rom_data;
            en_in   <= 1'b1;
            rom_req <= 1'b0;
            state   <= VALID;
          end else if (wait_cnt == CNT_LAST) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            err      <= 1'b1;
            rom_req  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        VALID: begin
          en_in <= 1'b0;
          state <= WAIT_PC;
        end

        WAIT_PC: begin
          if (en_pc_pulse) begin
            pc <= pc_next;
            if (en) begin
              state    <= FETCH;
              rom_req  <= 1'b1;
              wait_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          rom_req <= 1'b0;
          en_in   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, ROM handshake, PC update modes,
// ack timeout, reset during fetch and en withdrawn mid-fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        en_pc_pulse;
  logic [1:0]  pc_ctrl;
  logic [7:0]  offset_addr;
  logic [7:0]  rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic [15:0] ins;
  logic        en_in;
  logic [7:0]  pc;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .en_pc_pulse (en_pc_pulse),
    .pc_ctrl     (pc_ctrl),
    .offset_addr (offset_addr),
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .ins         (ins),
    .en_in       (en_in),
    .pc          (pc),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one fetch; the ROM acks after ack_delay wait cycles.
  task automatic do_fetch(input int ack_delay, input logic [15:0] data,
                          input logic [7:0] exp_addr);
    int reqs;
    reqs = 0;
    for (int w = 0; w < 4 && !rom_req; w++) tick();
    check("req_start", 32'(rom_req), 32'd1);
    check("rom_addr", 32'(rom_addr), 32'(exp_addr));
    for (int k = 0; k <= ack_delay; k++) begin
      if (rom_req) reqs++;
      if (k == ack_delay) begin
        rom_ack  = 1'b1;
        rom_data = data;
      end
      tick();
    end
    rom_ack  = 1'b0;
    rom_data = 16'hA5A5;
    check("req_cycles", 32'(reqs), 32'(ack_delay + 1));
    check("ins_capture", 32'(ins), 32'(data));
    check("en_in_valid", 32'(en_in), 32'd1);
    check("req_valid", 32'(rom_req), 32'd0);
    tick();
    check("en_in_once", 32'(en_in), 32'd0);
    check("busy_wait_pc", 32'(busy), 32'd1);
  endtask

  task automatic pc_step(input logic [1:0] ctrl, input logic [7:0] off,
                         input logic [7:0] exp_pc);
    en_pc_pulse = 1'b1;
    pc_ctrl     = ctrl;
    offset_addr = off;
    tick();
    en_pc_pulse = 1'b0;
    offset_addr = 8'h00;
    check("pc_update", 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; en_pc_pulse = 1'b0; pc_ctrl = 2'b00;
    offset_addr = 8'h00; rom_ack = 1'b0; rom_data = 16'h0000;
    tick();
    tick();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ins", 32'(ins), 32'd0);
    check("rst_req", 32'(rom_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en_in", 32'(en_in), 32'd0);
    rst = 1'b0;

    // Basic fetch: ack two cycles after the request.
    en = 1'b1;
    do_fetch(2, 16'h1234, 8'h00);

    // PC update modes, each confirmed by the next fetch address.
    pc_step(2'b10, 8'h05, 8'h05);
    do_fetch(0, 16'h1111, 8'h05);
    pc_step(2'b01, 8'h00, 8'h06);
    do_fetch(1, 16'h2222, 8'h06);
    pc_step(2'b10, 8'hFF, 8'hFF);
    do_fetch(0, 16'h3333, 8'hFF);
    pc_step(2'b01, 8'h00, 8'h00);
    do_fetch(0, 16'h4444, 8'h00);
    pc_step(2'b10, 8'h10, 8'h10);
    do_fetch(0, 16'h5555, 8'h10);
    pc_step(2'b11, 8'hFC, 8'h0C);
    do_fetch(0, 16'h6666, 8'h0C);
    pc_step(2'b00, 8'h55, 8'h0C);
    do_fetch(0, 16'h7777, 8'h0C);
    pc_step(2'b10, 8'h10, 8'h10);
    do_fetch(0, 16'h8888, 8'h10);
    pc_step(2'b10, 8'h80, 8'h80);

    // Ack on the last allowed cycle still captures.
    do_fetch(14, 16'hBEEF, 8'h80);
    check("no_err_late_ack", 32'(err), 32'd0);

    // Timeout: never ack; en drops and en_pc_pulse toggles during FETCH.
    pc_step(2'b00, 8'h00, 8'h80);
    en = 1'b0;
    n = 0;
    while (rom_req && n < 40) begin
      n++;
      en_pc_pulse = 1'b1;
      pc_ctrl     = 2'b01;
      tick();
    end
    en_pc_pulse = 1'b0;
    check("timeout_cycles", 32'(n), 32'd15);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_req", 32'(rom_req), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_pc", 32'(pc), 32'h80);
    check("timeout_ins", 32'(ins), 32'hBEEF);

    // In IDLE, PC strobes and stray acks are ignored.
    en_pc_pulse = 1'b1;
    pc_ctrl     = 2'b01;
    rom_ack     = 1'b1;
    rom_data    = 16'hDEAD;
    tick();
    en_pc_pulse = 1'b0;
    rom_ack     = 1'b0;
    check("idle_pc", 32'(pc), 32'h80);
    check("idle_ins", 32'(ins), 32'hBEEF);
    check("idle_en_in", 32'(en_in), 32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("err_sticky", 32'(err), 32'd1);

    // Reset on the second FETCH cycle.
    en = 1'b1;
    tick();
    check("mid_req1", 32'(rom_req), 32'd1);
    tick();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_req", 32'(rom_req), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_ins", 32'(ins), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);

    // en withdrawn mid-FETCH: fetch completes, then FSM returns to IDLE.
    en = 1'b1;
    tick();
    check("drop_req", 32'(rom_req), 32'd1);
    en       = 1'b0;
    tick();
    rom_ack  = 1'b1;
    rom_data = 16'h0F0F;
    tick();
    rom_ack  = 1'b0;
    check("drop_en_in", 32'(en_in), 32'd1);
    check("drop_ins", 32'(ins), 32'h0F0F);
    tick();
    check("drop_busy_wait", 32'(busy), 32'd1);
    pc_step(2'b01, 8'h00, 8'h01);
    check("drop_idle_busy", 32'(busy), 32'd0);
    tick();
    check("drop_idle_req", 32'(rom_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
